// File: rtl/uart_tx_monitor_if.sv
// -----------------------------------------------------------------------------
// uart_tx_monitor_if
// Byte stream leaving the UART TX monitor: the head of its output FIFO
// together with the consumer handshake.
//   data_o  : byte at FIFO head (driven by the monitor)
//   valid_o : FIFO not empty (driven by the monitor)
//   ready_i : consumer accepts data_o when valid_o && ready_i (driven by consumer)
// Modports: master = the monitor, slave = the consumer.
// -----------------------------------------------------------------------------
interface uart_tx_monitor_if;
   logic [7:0] data_o;
   logic       valid_o;
   logic       ready_i;

   modport master (output data_o, output valid_o, input ready_i);
   modport slave  (input data_o, input valid_o, output ready_i);
endinterface

// File: rtl/uart_tx_monitor.sv
// -----------------------------------------------------------------------------
// uart_tx_monitor
// Passive receiver for the system UART TX line. Oversamples the line at the
// system clock, recovers 8N1 frames and buffers good bytes in a small FIFO.
// Bad stop bits are flagged and counted; bytes lost to a full FIFO are flagged.
//
// Ports:
//   clk_i        in   system clock
//   rst_ni       in   synchronous active-low reset
//   enable_i     in   monitor enable; low abandons any frame in progress
//   rx_i         in   serial line, idle high
//   out_if       --   master side of uart_tx_monitor_if (data_o/valid_o/ready_i)
//   frame_err_o  out  one-cycle pulse on a framing (or parity) error
//   overflow_o   out  one-cycle pulse when a good byte is dropped (FIFO full)
//   err_count_o  out  saturating framing-error count
//   busy_o       out  FSM is not idle
//
// Optional feature: define UART_MON_PARITY_EN to expect an even parity bit
// between the data bits and the stop bit (8E1). Default build is 8N1.
// -----------------------------------------------------------------------------
module uart_tx_monitor #(
   parameter int unsigned SysClkFreq = 30_000_000,
   parameter int unsigned BaudRate   = 921_600,
   parameter int unsigned FifoDepth  = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                enable_i,
   input  logic                rx_i,
   uart_tx_monitor_if.master   out_if,
   output logic                frame_err_o,
   output logic                overflow_o,
   output logic [15:0]         err_count_o,
   output logic                busy_o
);

   localparam int unsigned ClksPerBit = SysClkFreq / BaudRate;
   localparam int unsigned HalfBit    = ClksPerBit / 32'd2;
   localparam int unsigned CntW       = $clog2(ClksPerBit);
   localparam int unsigned PtrW       = $clog2(FifoDepth);

   localparam logic [CntW-1:0] CntBit  = CntW'(ClksPerBit - 32'd1);
   localparam logic [CntW-1:0] CntHalf = CntW'(HalfBit - 32'd1);
   localparam logic [CntW-1:0] CntZero = {CntW{1'b0}};
   localparam logic [CntW-1:0] CntOne  = {{(CntW-1){1'b0}}, 1'b1};
   localparam logic [PtrW:0]   PtrOne  = {{PtrW{1'b0}}, 1'b1};

   generate
      if (ClksPerBit < 32'd4) begin : g_bad_clks_per_bit
         $error("uart_tx_monitor: ClksPerBit must be at least 4");
      end
      if ((FifoDepth < 32'd2) || ((FifoDepth & (FifoDepth - 32'd1)) != 32'd0)) begin : g_bad_depth
         $error("uart_tx_monitor: FifoDepth must be a power of two >= 2");
      end
   endgenerate

`ifdef UART_MON_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_IDLE = 3'd4,
      ST_PARITY    = 3'd5
   } state_e;
`else
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_IDLE = 3'd4
   } state_e;
`endif

   // Saturating increment for the error counter.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      if (v == 16'hFFFF) begin
         return v;
      end else begin
         return v + 16'd1;
      end
   endfunction

`ifdef UART_MON_PARITY_EN
   // Even parity holds when data bits plus parity bit have an even number of ones.
   function automatic logic even_parity_ok(input logic [7:0] d, input logic p);
      return ~(^{d, p});
   endfunction
`endif

   logic                sync1_r, rx_sync_r, rx_prev_r;
   state_e              state_r, state_n;
   logic [CntW-1:0]     cnt_r, cnt_n;
   logic [2:0]          bit_idx_r, bit_idx_n;
   logic [7:0]          shift_r, shift_n;
`ifdef UART_MON_PARITY_EN
   logic                par_bad_r, par_bad_n;
`endif
   logic                push_s, ferr_s, fall_s, cnt_zero_s;
   logic                frame_err_r, overflow_r;
   logic [15:0]         err_count_r;

   logic [7:0]          mem_r [FifoDepth];
   logic [PtrW:0]       wr_ptr_r, rd_ptr_r;
   logic                empty_s, full_s, pop_s, wr_en_s, overflow_s;

   assign fall_s     = rx_prev_r & ~rx_sync_r;
   assign cnt_zero_s = (cnt_r == CntZero);

   // Two-flop synchroniser plus one history flop for edge detection.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync1_r   <= 1'b1;
         rx_sync_r <= 1'b1;
         rx_prev_r <= 1'b1;
      end else begin
         sync1_r   <= rx_i;
         rx_sync_r <= sync1_r;
         rx_prev_r <= rx_sync_r;
      end
   end

   // FSM and bit-timing registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_r   <= ST_IDLE;
         cnt_r     <= CntZero;
         bit_idx_r <= 3'd0;
         shift_r   <= 8'h00;
`ifdef UART_MON_PARITY_EN
         par_bad_r <= 1'b0;
`endif
      end else begin
         state_r   <= state_n;
         cnt_r     <= cnt_n;
         bit_idx_r <= bit_idx_n;
         shift_r   <= shift_n;
`ifdef UART_MON_PARITY_EN
         par_bad_r <= par_bad_n;
`endif
      end
   end

   // Next-state, bit timing, push and framing-error decisions.
   always_comb begin
      state_n   = state_r;
      cnt_n     = cnt_r;
      bit_idx_n = bit_idx_r;
      shift_n   = shift_r;
      push_s    = 1'b0;
      ferr_s    = 1'b0;
`ifdef UART_MON_PARITY_EN
      par_bad_n = par_bad_r;
`endif
      if (!enable_i) begin
         state_n = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (fall_s) begin
                  state_n = ST_START;
                  cnt_n   = CntHalf;
               end else begin
                  state_n = ST_IDLE;
               end
            end
            ST_START: begin
               if (!cnt_zero_s) begin
                  cnt_n = cnt_r - CntOne;
               end else if (!rx_sync_r) begin
                  state_n   = ST_DATA;
                  cnt_n     = CntBit;
                  bit_idx_n = 3'd0;
               end else begin
                  // Line back high at mid start bit: treat as a glitch.
                  state_n = ST_IDLE;
               end
            end
            ST_DATA: begin
               if (!cnt_zero_s) begin
                  cnt_n = cnt_r - CntOne;
               end else begin
                  shift_n = {rx_sync_r, shift_r[7:1]};
                  cnt_n   = CntBit;
                  if (bit_idx_r == 3'd7) begin
`ifdef UART_MON_PARITY_EN
                     state_n = ST_PARITY;
`else
                     state_n = ST_STOP;
`endif
                  end else begin
                     bit_idx_n = bit_idx_r + 3'd1;
                  end
               end
            end
`ifdef UART_MON_PARITY_EN
            ST_PARITY: begin
               if (!cnt_zero_s) begin
                  cnt_n = cnt_r - CntOne;
               end else begin
                  cnt_n   = CntBit;
                  state_n = ST_STOP;
                  if (even_parity_ok(shift_r, rx_sync_r)) begin
                     par_bad_n = 1'b0;
                  end else begin
                     par_bad_n = 1'b1;
                     ferr_s    = 1'b1;
                  end
               end
            end
`endif
            ST_STOP: begin
               if (!cnt_zero_s) begin
                  cnt_n = cnt_r - CntOne;
               end else if (rx_sync_r) begin
                  state_n = ST_IDLE;
`ifdef UART_MON_PARITY_EN
                  push_s  = ~par_bad_r;
`else
                  push_s  = 1'b1;
`endif
               end else begin
                  // Bad stop: wait for the line to return high so a break
                  // is reported only once. A parity failure already counted.
                  state_n = ST_WAIT_IDLE;
`ifdef UART_MON_PARITY_EN
                  ferr_s  = ~par_bad_r;
`else
                  ferr_s  = 1'b1;
`endif
               end
            end
            ST_WAIT_IDLE: begin
               if (rx_sync_r) begin
                  state_n = ST_IDLE;
               end else begin
                  state_n = ST_WAIT_IDLE;
               end
            end
            default: begin
               state_n = ST_IDLE;
            end
         endcase
      end
   end

   assign empty_s    = (wr_ptr_r == rd_ptr_r);
   assign full_s     = (wr_ptr_r[PtrW-1:0] == rd_ptr_r[PtrW-1:0]) &&
                       (wr_ptr_r[PtrW] != rd_ptr_r[PtrW]);
   assign pop_s      = ~empty_s & out_if.ready_i;
   // A pop in the same cycle frees the slot the push needs.
   assign wr_en_s    = push_s & (~full_s | pop_s);
   assign overflow_s = push_s & full_s & ~pop_s;

   // FIFO storage and pointers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         mem_r    <= '{default: 8'h00};
         wr_ptr_r <= {(PtrW+1){1'b0}};
         rd_ptr_r <= {(PtrW+1){1'b0}};
      end else begin
         if (wr_en_s) begin
            mem_r[wr_ptr_r[PtrW-1:0]] <= shift_r;
            wr_ptr_r                  <= wr_ptr_r + PtrOne;
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PtrOne;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
      end
   end

   // Error pulses and saturating error counter.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         frame_err_r <= 1'b0;
         overflow_r  <= 1'b0;
         err_count_r <= 16'h0000;
      end else begin
         frame_err_r <= ferr_s;
         overflow_r  <= overflow_s;
         if (ferr_s) begin
            err_count_r <= sat_inc16(err_count_r);
         end else begin
            err_count_r <= err_count_r;
         end
      end
   end

   assign out_if.data_o  = mem_r[rd_ptr_r[PtrW-1:0]];
   assign out_if.valid_o = ~empty_s;
   assign frame_err_o    = frame_err_r;
   assign overflow_o     = overflow_r;
   assign err_count_o    = err_count_r;
   assign busy_o         = (state_r != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_monitor.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_monitor
// Directed bench for uart_tx_monitor at default parameters (32 clocks/bit).
// A table of frames is replayed first, then hand-written sequences cover the
// glitch, break, overflow, coincident push/pop, enable drop and reset cases.
// Define UART_MON_PARITY_EN for both the RTL and this bench to test 8E1.
// -----------------------------------------------------------------------------
module tb_uart_tx_monitor;

   localparam int CPB  = 32;
   localparam int HALF = 16;
`ifdef UART_MON_PARITY_EN
   localparam int FRAME_BITS = 11;
   localparam int NVEC       = 9;
`else
   localparam int FRAME_BITS = 10;
   localparam int NVEC       = 6;
`endif
   // Negedges from driving the start bit to the negedge before the stop sample.
   localparam int POP_WAIT = 2 + HALF + CPB * (FRAME_BITS - 1);

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       par_flip;
      int         exp_bytes;
      int         exp_errs;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        rx;
   logic        frame_err;
   logic        overflow;
   logic [15:0] err_count;
   logic        busy;

   uart_tx_monitor_if mon_if ();

   uart_tx_monitor dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .enable_i    (enable),
      .rx_i        (rx),
      .out_if      (mon_if),
      .frame_err_o (frame_err),
      .overflow_o  (overflow),
      .err_count_o (err_count),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] got_q[$];
   int         err_pulses   = 0;
   int         ovf_pulses   = 0;
   int         valid_cycles = 0;
   int         exp_err      = 0;
   vec_t       vecs [NVEC];

   // Observe the output side just before each rising edge.
   always begin
      @(negedge clk);
      #4;
      if (mon_if.valid_o === 1'b1) valid_cycles++;
      if (mon_if.valid_o === 1'b1 && mon_if.ready_i === 1'b1) got_q.push_back(mon_if.data_o);
      if (frame_err === 1'b1) err_pulses++;
      if (overflow === 1'b1) ovf_pulses++;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one frame starting at the current negedge, LSB first.
   task automatic send_frame(input logic [7:0] d, input logic stop,
                             input logic par_flip, input int hold_low);
      rx = 1'b0;
      idle(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         idle(CPB);
      end
`ifdef UART_MON_PARITY_EN
      rx = (^d) ^ par_flip;
      idle(CPB);
`else
      if (par_flip) rx = 1'b1;
`endif
      rx = stop;
      idle(CPB);
      if (!stop) idle(hold_low);
      rx = 1'b1;
   endtask

   initial begin
      vecs[0] = '{8'h55, 1'b1, 1'b0, 1, 0};
      vecs[1] = '{8'h00, 1'b1, 1'b0, 1, 0};
      vecs[2] = '{8'hFF, 1'b1, 1'b0, 1, 0};
      vecs[3] = '{8'h80, 1'b1, 1'b0, 1, 0};
      vecs[4] = '{8'h5A, 1'b0, 1'b0, 0, 1};
      vecs[5] = '{8'h01, 1'b1, 1'b0, 1, 0};
`ifdef UART_MON_PARITY_EN
      vecs[6] = '{8'h07, 1'b1, 1'b0, 1, 0};
      vecs[7] = '{8'h07, 1'b1, 1'b1, 0, 1};
      vecs[8] = '{8'h07, 1'b0, 1'b1, 0, 1};
`endif

      mon_if.ready_i = 1'b1;
      rst_n  = 1'b0;
      enable = 1'b0;
      rx     = 1'b1;
      idle(3);
      chk("reset data_o", {24'd0, mon_if.data_o}, 32'h0);
      chk("reset valid_o", {31'd0, mon_if.valid_o}, 32'h0);
      chk("reset frame_err_o", {31'd0, frame_err}, 32'h0);
      chk("reset overflow_o", {31'd0, overflow}, 32'h0);
      chk("reset err_count_o", {16'd0, err_count}, 32'h0);
      chk("reset busy_o", {31'd0, busy}, 32'h0);
      rst_n  = 1'b1;
      enable = 1'b1;
      idle(5);

      // Table of single frames with ready_i held high.
      for (int v = 0; v < NVEC; v++) begin
         got_q.delete();
         err_pulses   = 0;
         valid_cycles = 0;
         send_frame(vecs[v].data, vecs[v].stop, vecs[v].par_flip, 0);
         idle(20);
         exp_err += vecs[v].exp_errs;
         chk($sformatf("vec%0d bytes", v), got_q.size(), vecs[v].exp_bytes);
         chk($sformatf("vec%0d valid cycles", v), valid_cycles, vecs[v].exp_bytes);
         if (got_q.size() > 0) chk($sformatf("vec%0d data", v), {24'd0, got_q[0]}, {24'd0, vecs[v].data});
         chk($sformatf("vec%0d err pulses", v), err_pulses, vecs[v].exp_errs);
         chk($sformatf("vec%0d err_count", v), {16'd0, err_count}, exp_err);
         chk($sformatf("vec%0d busy", v), {31'd0, busy}, 32'h0);
      end

      // Short low glitch on an idle line.
      got_q.delete();
      err_pulses = 0;
      rx = 1'b0;
      idle(8);
      rx = 1'b1;
      idle(2);
      chk("glitch busy mid", {31'd0, busy}, 32'h1);
      idle(12);
      chk("glitch busy after", {31'd0, busy}, 32'h0);
      chk("glitch bytes", got_q.size(), 0);
      chk("glitch err pulses", err_pulses, 0);

      // Break: bad stop bit, line held low, then a clean byte.
      got_q.delete();
      err_pulses = 0;
      send_frame(8'hA5, 1'b0, 1'b0, 100);
      idle(20);
      exp_err += 1;
      chk("break err pulses", err_pulses, 1);
      chk("break err_count", {16'd0, err_count}, exp_err);
      chk("break bytes", got_q.size(), 0);
      send_frame(8'h3C, 1'b1, 1'b0, 0);
      idle(20);
      chk("after break bytes", got_q.size(), 1);
      if (got_q.size() > 0) chk("after break data", {24'd0, got_q[0]}, 32'h3C);
      chk("after break err pulses", err_pulses, 1);

      // Overflow: nine bytes back-to-back with no consumer.
      got_q.delete();
      ovf_pulses = 0;
      mon_if.ready_i = 1'b0;
      for (int i = 0; i < 8; i++) send_frame(8'(i), 1'b1, 1'b0, 0);
      chk("fill no overflow", ovf_pulses, 0);
      send_frame(8'h08, 1'b1, 1'b0, 0);
      idle(20);
      chk("overflow pulses", ovf_pulses, 1);
      chk("full valid_o", {31'd0, mon_if.valid_o}, 32'h1);
      chk("full head", {24'd0, mon_if.data_o}, 32'h00);
      mon_if.ready_i = 1'b1;
      idle(20);
      chk("drain count", got_q.size(), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < got_q.size()) chk($sformatf("drain byte%0d", i), {24'd0, got_q[i]}, i);
      end
      chk("drained valid_o", {31'd0, mon_if.valid_o}, 32'h0);

      // Full FIFO: pop lands in the same cycle as the new byte's stop sample.
      got_q.delete();
      ovf_pulses = 0;
      mon_if.ready_i = 1'b0;
      for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0, 0);
      fork
         send_frame(8'h99, 1'b1, 1'b0, 0);
         begin
            idle(POP_WAIT);
            mon_if.ready_i = 1'b1;
            idle(1);
            mon_if.ready_i = 1'b0;
         end
      join
      idle(20);
      chk("coincident overflow", ovf_pulses, 0);
      chk("coincident popped", got_q.size(), 1);
      mon_if.ready_i = 1'b1;
      idle(20);
      chk("coincident drain count", got_q.size(), 9);
      for (int i = 0; i < 8; i++) begin
         if (i < got_q.size()) chk($sformatf("coinc byte%0d", i), {24'd0, got_q[i]}, 32'h10 + i);
      end
      if (got_q.size() > 8) chk("coinc last byte", {24'd0, got_q[8]}, 32'h99);

      // enable_i dropped mid-byte.
      got_q.delete();
      err_pulses = 0;
      fork
         send_frame(8'h42, 1'b1, 1'b0, 0);
         begin
            idle(100);
            enable = 1'b0;
            idle(2);
            chk("disable busy", {31'd0, busy}, 32'h0);
         end
      join
      idle(20);
      enable = 1'b1;
      idle(5);
      chk("disable bytes", got_q.size(), 0);
      chk("disable err pulses", err_pulses, 0);
      chk("disable err_count", {16'd0, err_count}, exp_err);

      // Reset mid-frame with a byte waiting in the FIFO.
      got_q.delete();
      mon_if.ready_i = 1'b0;
      send_frame(8'h66, 1'b1, 1'b0, 0);
      idle(10);
      chk("pre-reset valid_o", {31'd0, mon_if.valid_o}, 32'h1);
      fork
         send_frame(8'h77, 1'b1, 1'b0, 0);
         begin
            idle(150);
            rst_n = 1'b0;
            idle(2);
            chk("midreset busy", {31'd0, busy}, 32'h0);
            chk("midreset valid_o", {31'd0, mon_if.valid_o}, 32'h0);
            chk("midreset data_o", {24'd0, mon_if.data_o}, 32'h0);
            chk("midreset err_count", {16'd0, err_count}, 32'h0);
         end
      join
      rst_n = 1'b1;
      mon_if.ready_i = 1'b1;
      idle(20);
      chk("post-reset bytes", got_q.size(), 0);
      chk("post-reset busy", {31'd0, busy}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
